pwm_duty_ramp: RTL and testbench
================================

PWM_DUTY_RAMP -- requirements
Module: pwm_duty_ramp

Interface
REQ-001 SHALL have parameter R, default 8: duty and period-counter width, PWM period = 2^R clk cycles.
REQ-002 SHALL have parameter RW, default 16: width of the rate input.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port en  input  1  1 = ramp toward target, 0 = soft-off (duty forced to 0).
REQ-006 SHALL have port target  input  R  requested final duty.
REQ-007 SHALL have port step  input  R  duty increment/decrement per step event; 0 treated as 1.
REQ-008 SHALL have port rate  input  RW  number of extra PWM periods between step events; 0 = step every period.
REQ-009 SHALL have port duty  output  R  registered duty, drives the downstream PWM generator's duty input.
REQ-010 SHALL have port period_start  output  1  registered one-cycle pulse marking the first cycle of each PWM period.
REQ-011 SHALL have port busy  output  1  registered, high while state = RAMP.
REQ-012 SHALL have port at_target  output  1  registered, high while state = LOCK.

Function
REQ-013 SHALL keep internal R-bit period counter pcnt, +1 per clk, wrapping 2^R-1 -> 0; the edge where pcnt wraps is the "wrap edge".
REQ-014 SHALL set period_start to 1 on each wrap edge and to 0 on every other edge, so it is high exactly when pcnt = 0.
REQ-015 SHALL sample en, target, step, rate only on wrap edges; changes between wrap edges SHALL have no effect.
REQ-016 SHALL change duty only on wrap edges, so duty and period_start change on the same edge (glitch-free for the downstream PWM).
REQ-017 SHALL keep an RW-bit period-divider rcnt; at each wrap edge with en = 1: step event when rcnt = rate, then rcnt <- 0; otherwise rcnt <- rcnt+1.
REQ-018 SHALL on a step event with duty < target set duty <- min(duty + step, target), sum computed in R+1 bits (no wrap, no overshoot).
REQ-019 SHALL on a step event with duty > target set duty <- max(duty - step, target), difference computed in R+1 bits (no underflow, no undershoot).
REQ-020 SHALL leave duty unchanged on wrap edges without a step event.
REQ-021 SHALL implement states IDLE, RAMP, LOCK, transitioning only on wrap edges, evaluated after the duty update of that edge.
REQ-022 SHALL transition any state -> IDLE when en = 0, with duty <- 0 and rcnt <- 0 on that edge.
REQ-023 SHALL transition IDLE/RAMP/LOCK -> RAMP when en = 1 and the new duty differs from target.
REQ-024 SHALL transition IDLE/RAMP/LOCK -> LOCK when en = 1 and the new duty equals target.
REQ-025 SHALL hold rcnt at 0 in IDLE, so the first step occurs on the first wrap edge with en = 1 if rate = 0, or rate periods later otherwise.
REQ-026 SHALL redirect the ramp from the current duty when target changes mid-ramp, with no restart of rcnt.
REQ-027 SHALL keep pcnt and period_start running regardless of en or state.

Reset
REQ-028 SHALL on any clk edge with rst = 1 set pcnt = 0, rcnt = 0, state = IDLE, duty = 0, period_start = 0, busy = 0, at_target = 0.
REQ-029 SHALL give reset priority over all other activity, including mid-ramp; the first period_start SHALL occur 2^R cycles after the last reset edge.

Verification (R = 8, RW = 16)
REQ-030 SHALL cover: release reset, en = 1, target = 64, step = 16, rate = 0 -> duty 16/32/48/64 at cycles 256/512/768/1024; busy 1 until 1024, at_target 1 from 1024.
REQ-031 SHALL cover: target = 50, step = 16, rate = 0 -> duty 16, 32, 48, 50, never above 50.
REQ-032 SHALL cover: locked at 64, target <- 0, step = 32, rate = 1 -> duty 32 after 2nd wrap, 0 after 4th wrap, then LOCK with at_target = 1.
REQ-033 SHALL cover: en <- 0 mid-ramp at pcnt = 100 -> duty 0 and busy 0 at next wrap edge; period_start continues every 256 cycles.
REQ-034 SHALL cover: target toggled 64 -> 200 -> 64 within one period, and step = 0 -> no effect from the toggle; duty advances by 1 per step event.
REQ-035 SHALL cover: rst pulsed for 1 cycle at pcnt = 100 mid-ramp -> all outputs 0 on the next edge; next period_start 256 cycles after release.

Source files
------------

// File: rtl/pwm_duty_ramp.sv
// Soft-start duty ramp for a downstream PWM generator: walks duty toward target
// in steps, updating only at period boundaries so the PWM never sees a mid-period change.
//
// state | meaning
// IDLE  | en low, duty held at 0, period divider cleared
// RAMP  | en high, duty still moving toward target
// LOCK  | en high, duty equals target
module pwm_duty_ramp #(
    parameter int R  = 8,
    parameter int RW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [R-1:0]  target,
    input  logic [R-1:0]  step,
    input  logic [RW-1:0] rate,
    output logic [R-1:0]  duty,
    output logic          period_start,
    output logic          busy,
    output logic          at_target
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam logic [R-1:0]  PCNT_MAX = {R{1'b1}};
    localparam logic [R-1:0]  P_ONE    = R'(1);
    localparam logic [RW-1:0] R_ONE    = RW'(1);

    logic [R-1:0]  pcnt_q, pcnt_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    state_t        state_q, state_d;
    logic [R-1:0]  duty_q, duty_d;
    logic          period_start_q, period_start_d;
    logic          busy_q, busy_d;
    logic          at_target_q, at_target_d;

    logic          wrap;
    logic          step_evt;
    logic [R-1:0]  step_eff;
    logic [R:0]    sum_up;
    logic [R:0]    diff_dn;
    logic [R:0]    tgt_x;
    logic [R-1:0]  duty_up;
    logic [R-1:0]  duty_dn;

    assign wrap     = (pcnt_q == PCNT_MAX);
    assign step_eff = (step == '0) ? P_ONE : step;
    assign tgt_x    = {1'b0, target};
    assign step_evt = wrap && en && (rcnt_q == rate);

    // One extra bit keeps the sum from wrapping and exposes underflow in bit R.
    assign sum_up  = {1'b0, duty_q} + {1'b0, step_eff};
    assign diff_dn = {1'b0, duty_q} - {1'b0, step_eff};
    assign duty_up = (sum_up > tgt_x) ? target : sum_up[R-1:0];
    assign duty_dn = (diff_dn[R] || (diff_dn < tgt_x)) ? target : diff_dn[R-1:0];

    always_comb begin
        pcnt_d         = pcnt_q + P_ONE;
        period_start_d = wrap;
        rcnt_d         = rcnt_q;
        duty_d         = duty_q;
        state_d        = state_q;
        busy_d         = busy_q;
        at_target_d    = at_target_q;

        if (wrap) begin
            if (!en) begin
                rcnt_d  = '0;
                duty_d  = '0;
                state_d = IDLE;
            end else begin
                if (step_evt) begin
                    rcnt_d = '0;
                    if (duty_q < target) begin
                        duty_d = duty_up;
                    end else if (duty_q > target) begin
                        duty_d = duty_dn;
                    end
                end else begin
                    rcnt_d = rcnt_q + R_ONE;
                end
                state_d = (duty_d == target) ? LOCK : RAMP;
            end
            busy_d      = (state_d == RAMP);
            at_target_d = (state_d == LOCK);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q         <= '0;
            rcnt_q         <= '0;
            state_q        <= IDLE;
            duty_q         <= '0;
            period_start_q <= 1'b0;
            busy_q         <= 1'b0;
            at_target_q    <= 1'b0;
        end else begin
            pcnt_q         <= pcnt_d;
            rcnt_q         <= rcnt_d;
            state_q        <= state_d;
            duty_q         <= duty_d;
            period_start_q <= period_start_d;
            busy_q         <= busy_d;
            at_target_q    <= at_target_d;
        end
    end

    assign duty         = duty_q;
    assign period_start = period_start_q;
    assign busy         = busy_q;
    assign at_target    = at_target_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Bench for pwm_duty_ramp: hand-derived per-period expectations are queued
// with the stimulus and checked at each period_start.
module tb_pwm_duty_ramp;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  target;
    logic [7:0]  step;
    logic [15:0] rate;
    logic [7:0]  duty;
    logic        period_start;
    logic        busy;
    logic        at_target;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] duty;
        logic       busy;
        logic       at_t;
    } exp_t;

    exp_t exp_q[$];

    pwm_duty_ramp #(.R(8), .RW(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .target       (target),
        .step         (step),
        .rate         (rate),
        .duty         (duty),
        .period_start (period_start),
        .busy         (busy),
        .at_target    (at_target)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [7:0] d, input logic b, input logic a);
        exp_t e;
        e.duty = d;
        e.busy = b;
        e.at_t = a;
        exp_q.push_back(e);
    endtask

    // Advance to the next period_start (sampled on negedge); cyc = negedges waited.
    task automatic next_period(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!period_start && cyc < 600);
        checks++;
        if (!period_start) begin
            errors++;
            $display("FAIL period_timeout: period_start=%0b after %0d cycles, want 1", period_start, cyc);
        end
    endtask

    task automatic test_reset();
        int cyc;
        rst = 1'b1; en = 1'b0; target = 8'd0; step = 8'd0; rate = 16'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({duty, busy, at_target, period_start} !== 11'd0) begin
            errors++;
            $display("FAIL reset_vals: duty/busy/at/ps=%0d/%0b/%0b/%0b want 0/0/0/0", duty, busy, at_target, period_start);
        end
        rst = 1'b0;
        next_period(cyc);
        checks++;
        if (cyc != 256) begin
            errors++;
            $display("FAIL reset_first_ps: %0d cycles want 256", cyc);
        end
        checks++;
        if ({duty, busy, at_target} !== {8'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_idle: duty/busy/at=%0d/%0b/%0b want 0/0/0", duty, busy, at_target);
        end
    endtask

    task automatic test_ramp_up();
        int cyc;
        exp_t e;
        en = 1'b1; target = 8'd64; step = 8'd16; rate = 16'd0;
        push(8'd16, 1'b1, 1'b0);
        push(8'd32, 1'b1, 1'b0);
        push(8'd48, 1'b1, 1'b0);
        push(8'd64, 1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            next_period(cyc);
            e = exp_q.pop_front();
            checks++;
            if ({duty, busy, at_target} !== {e.duty, e.busy, e.at_t}) begin
                errors++;
                $display("FAIL ramp_up: duty/busy/at=%0d/%0b/%0b want %0d/%0b/%0b", duty, busy, at_target, e.duty, e.busy, e.at_t);
            end
            checks++;
            if (cyc != 256) begin
                errors++;
                $display("FAIL ramp_up_period: %0d cycles want 256", cyc);
            end
        end
    endtask

    task automatic test_lock_down();
        int cyc;
        exp_t e;
        target = 8'd0; step = 8'd32; rate = 16'd1;
        push(8'd64, 1'b1, 1'b0);
        push(8'd32, 1'b1, 1'b0);
        push(8'd32, 1'b1, 1'b0);
        push(8'd0,  1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            next_period(cyc);
            e = exp_q.pop_front();
            checks++;
            if ({duty, busy, at_target} !== {e.duty, e.busy, e.at_t}) begin
                errors++;
                $display("FAIL lock_down: duty/busy/at=%0d/%0b/%0b want %0d/%0b/%0b", duty, busy, at_target, e.duty, e.busy, e.at_t);
            end
        end
    endtask

    task automatic test_clamp();
        int cyc;
        exp_t e;
        target = 8'd50; step = 8'd16; rate = 16'd0;
        push(8'd16, 1'b1, 1'b0);
        push(8'd32, 1'b1, 1'b0);
        push(8'd48, 1'b1, 1'b0);
        push(8'd50, 1'b0, 1'b1);
        push(8'd50, 1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            next_period(cyc);
            e = exp_q.pop_front();
            checks++;
            if ({duty, busy, at_target} !== {e.duty, e.busy, e.at_t}) begin
                errors++;
                $display("FAIL clamp: duty/busy/at=%0d/%0b/%0b want %0d/%0b/%0b", duty, busy, at_target, e.duty, e.busy, e.at_t);
            end
        end
    endtask

    task automatic test_toggle();
        int cyc;
        exp_t e;
        logic [7:0] duty_start;
        target = 8'd64; step = 8'd0;
        push(8'd51, 1'b1, 1'b0);
        push(8'd52, 1'b1, 1'b0);
        push(8'd53, 1'b1, 1'b0);
        while (exp_q.size() > 0) begin
            duty_start = duty;
            repeat (50) @(negedge clk);
            target = 8'd200;
            repeat (100) @(negedge clk);
            target = 8'd64;
            checks++;
            if (duty !== duty_start) begin
                errors++;
                $display("FAIL toggle_midperiod: duty=%0d want %0d", duty, duty_start);
            end
            next_period(cyc);
            e = exp_q.pop_front();
            checks++;
            if ({duty, busy, at_target} !== {e.duty, e.busy, e.at_t}) begin
                errors++;
                $display("FAIL toggle: duty/busy/at=%0d/%0b/%0b want %0d/%0b/%0b", duty, busy, at_target, e.duty, e.busy, e.at_t);
            end
        end
    endtask

    task automatic test_soft_off();
        int cyc;
        exp_t e;
        push(8'd0, 1'b0, 1'b0);
        push(8'd0, 1'b0, 1'b0);
        repeat (100) @(negedge clk);
        en = 1'b0;
        next_period(cyc);
        checks++;
        if (cyc != 156) begin
            errors++;
            $display("FAIL soft_off_wrap: %0d cycles want 156", cyc);
        end
        e = exp_q.pop_front();
        checks++;
        if ({duty, busy, at_target} !== {e.duty, e.busy, e.at_t}) begin
            errors++;
            $display("FAIL soft_off: duty/busy/at=%0d/%0b/%0b want %0d/%0b/%0b", duty, busy, at_target, e.duty, e.busy, e.at_t);
        end
        next_period(cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc != 256 || {duty, busy, at_target} !== {e.duty, e.busy, e.at_t}) begin
            errors++;
            $display("FAIL soft_off_idle: cyc=%0d duty/busy/at=%0d/%0b/%0b want 256 %0d/%0b/%0b", cyc, duty, busy, at_target, e.duty, e.busy, e.at_t);
        end
    endtask

    task automatic test_rst_mid();
        int cyc;
        exp_t e;
        en = 1'b1; target = 8'd200; step = 8'd16; rate = 16'd0;
        push(8'd16, 1'b1, 1'b0);
        next_period(cyc);
        e = exp_q.pop_front();
        checks++;
        if ({duty, busy, at_target} !== {e.duty, e.busy, e.at_t}) begin
            errors++;
            $display("FAIL rst_mid_pre: duty/busy/at=%0d/%0b/%0b want %0d/%0b/%0b", duty, busy, at_target, e.duty, e.busy, e.at_t);
        end
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({duty, busy, at_target, period_start} !== 11'd0) begin
            errors++;
            $display("FAIL rst_mid_vals: duty/busy/at/ps=%0d/%0b/%0b/%0b want 0/0/0/0", duty, busy, at_target, period_start);
        end
        rst = 1'b0;
        push(8'd16, 1'b1, 1'b0);
        next_period(cyc);
        checks++;
        if (cyc != 256) begin
            errors++;
            $display("FAIL rst_mid_ps: %0d cycles want 256", cyc);
        end
        e = exp_q.pop_front();
        checks++;
        if ({duty, busy, at_target} !== {e.duty, e.busy, e.at_t}) begin
            errors++;
            $display("FAIL rst_mid_post: duty/busy/at=%0d/%0b/%0b want %0d/%0b/%0b", duty, busy, at_target, e.duty, e.busy, e.at_t);
        end
    endtask

    task automatic test_rate();
        int cyc;
        exp_t e;
        en = 1'b0;
        next_period(cyc);
        checks++;
        if ({duty, busy, at_target} !== {8'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rate_idle: duty/busy/at=%0d/%0b/%0b want 0/0/0", duty, busy, at_target);
        end
        en = 1'b1; target = 8'd40; step = 8'd20; rate = 16'd2;
        push(8'd0,  1'b1, 1'b0);
        push(8'd0,  1'b1, 1'b0);
        push(8'd20, 1'b1, 1'b0);
        push(8'd20, 1'b1, 1'b0);
        push(8'd20, 1'b1, 1'b0);
        push(8'd40, 1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            next_period(cyc);
            e = exp_q.pop_front();
            checks++;
            if ({duty, busy, at_target} !== {e.duty, e.busy, e.at_t}) begin
                errors++;
                $display("FAIL rate: duty/busy/at=%0d/%0b/%0b want %0d/%0b/%0b", duty, busy, at_target, e.duty, e.busy, e.at_t);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_lock_down();
        test_clamp();
        test_toggle();
        test_soft_off();
        test_rst_mid();
        test_rate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
